// File: rtl/render_scan_sequencer.sv
// Frame sequencer feeding the renderer: snapshots the scene on a frame request, waits for the
// float converters to settle, then streams every window coordinate over valid/ready.
module render_scan_sequencer #(
    parameter int START_X       = 390,
    parameter int START_Y       = 390,
    parameter int END_X         = 634,
    parameter int END_Y         = 765,
    parameter int REGION_DIVIDE = 530,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                frame_start_in,
    input  logic [10:0]         ball_x_in,
    input  logic [9:0]          ball_y_in,
    input  logic [9:0][10:0]    pins_x_in,
    input  logic [9:0][9:0]     pins_y_in,
    output logic [10:0]         ball_x_out,
    output logic [9:0]          ball_y_out,
    output logic [9:0][10:0]    pins_x_out,
    output logic [9:0][9:0]     pins_y_out,
    output logic [10:0]         hcount_out,
    output logic [9:0]          vcount_out,
    output logic [1:0]          select_objs_out,
    output logic                coord_valid_out,
    input  logic                coord_ready_in,
    output logic                busy_out,
    output logic                frame_done_out,
    output logic [7:0]          overrun_count_out
);

    localparam logic [10:0] FIRST_X = 11'(START_X);
    localparam logic [10:0] LAST_X  = 11'(END_X - 1);
    localparam logic [9:0]  FIRST_Y = 10'(START_Y);
    localparam logic [9:0]  LAST_Y  = 10'(END_Y - 1);
    localparam logic [9:0]  DIVIDE_Y = 10'(REGION_DIVIDE);
    localparam logic [7:0]  SETTLE  = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLING, SCAN, DONE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     settle_cnt_q, settle_cnt_d;
    logic [10:0]    hcount_q, hcount_d;
    logic [9:0]     vcount_q, vcount_d;
    logic [1:0]     select_q, select_d;
    logic           valid_q, valid_d;
    logic [7:0]     overrun_q, overrun_d;
    logic           snap_load;

    logic [10:0]        ball_x_q;
    logic [9:0]         ball_y_q;
    logic [9:0][10:0]   pins_x_q;
    logic [9:0][9:0]    pins_y_q;

    function automatic logic [1:0] region_select(input logic [9:0] v);
        return (v < DIVIDE_Y) ? 2'b11 : 2'b10;
    endfunction

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        select_d     = select_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        snap_load    = 1'b0;

        // Requests outside IDLE are dropped but counted, saturating.
        if (frame_start_in && state_q != IDLE && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    state_d      = SETTLING;
                    settle_cnt_d = 8'd0;
                    snap_load    = 1'b1;
                end
            end
            SETTLING: begin
                if (settle_cnt_q == SETTLE) begin
                    state_d  = SCAN;
                    hcount_d = FIRST_X;
                    vcount_d = FIRST_Y;
                    select_d = region_select(FIRST_Y);
                    valid_d  = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SCAN: begin
                if (valid_q && coord_ready_in) begin
                    if (hcount_q < LAST_X) begin
                        hcount_d = hcount_q + 11'd1;
                    end else if (vcount_q >= LAST_Y) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        hcount_d = FIRST_X;
                        vcount_d = vcount_q + 10'd1;
                        select_d = region_select(vcount_q + 10'd1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            settle_cnt_q <= 8'd0;
            hcount_q     <= 11'd0;
            vcount_q     <= 10'd0;
            select_q     <= 2'b00;
            valid_q      <= 1'b0;
            overrun_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            select_q     <= select_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Scene snapshot: held stable for the whole pass so the renderer sees one consistent scene.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ball_x_q <= '0;
            ball_y_q <= '0;
            pins_x_q <= '0;
            pins_y_q <= '0;
        end else if (snap_load) begin
            ball_x_q <= ball_x_in;
            ball_y_q <= ball_y_in;
            pins_x_q <= pins_x_in;
            pins_y_q <= pins_y_in;
        end
    end

    assign ball_x_out        = ball_x_q;
    assign ball_y_out        = ball_y_q;
    assign pins_x_out        = pins_x_q;
    assign pins_y_out        = pins_y_q;
    assign hcount_out        = hcount_q;
    assign vcount_out        = vcount_q;
    assign select_objs_out   = select_q;
    assign coord_valid_out   = valid_q;
    assign busy_out          = (state_q != IDLE);
    assign frame_done_out    = (state_q == DONE);
    assign overrun_count_out = overrun_q;

endmodule

// File: tb/tb_render_scan_sequencer.sv
// Directed bench for render_scan_sequencer on a reduced window that straddles the region divide;
// expected beats are queued at each request and popped as the DUT hands beats over.
module tb_render_scan_sequencer;

    localparam int SX = 390;
    localparam int SY = 525;
    localparam int EX = 398;
    localparam int EY = 535;
    localparam int RD = 530;
    localparam int ST = 8;
    localparam int BEATS = (EX - SX) * (EY - SY);

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic [1:0]  s;
    } beat_t;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               frame_start_in = 1'b0;
    logic [10:0]        ball_x_in = 11'd100;
    logic [9:0]         ball_y_in = 10'd50;
    logic [9:0][10:0]   pins_x_in = '0;
    logic [9:0][9:0]    pins_y_in = '0;
    logic [10:0]        ball_x_out;
    logic [9:0]         ball_y_out;
    logic [9:0][10:0]   pins_x_out;
    logic [9:0][9:0]    pins_y_out;
    logic [10:0]        hcount_out;
    logic [9:0]         vcount_out;
    logic [1:0]         select_objs_out;
    logic               coord_valid_out;
    logic               coord_ready_in = 1'b1;
    logic               busy_out;
    logic               frame_done_out;
    logic [7:0]         overrun_count_out;

    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];
    logic [10:0]        exp_bx;
    logic [9:0]         exp_by;
    logic [9:0][10:0]   exp_px;
    logic [9:0][9:0]    exp_py;
    bit                 was_reset;

    render_scan_sequencer #(
        .START_X(SX), .START_Y(SY), .END_X(EX), .END_Y(EY),
        .REGION_DIVIDE(RD), .SETTLE_CYCLES(ST)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .ball_x_in(ball_x_in), .ball_y_in(ball_y_in),
        .pins_x_in(pins_x_in), .pins_y_in(pins_y_in),
        .ball_x_out(ball_x_out), .ball_y_out(ball_y_out),
        .pins_x_out(pins_x_out), .pins_y_out(pins_y_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .select_objs_out(select_objs_out), .coord_valid_out(coord_valid_out),
        .coord_ready_in(coord_ready_in), .busy_out(busy_out),
        .frame_done_out(frame_done_out), .overrun_count_out(overrun_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_h"}, hcount_out, 0);
        chk({tag, "_v"}, vcount_out, 0);
        chk({tag, "_sel"}, select_objs_out, 0);
        chk({tag, "_valid"}, coord_valid_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, frame_done_out, 0);
        chk({tag, "_ovr"}, overrun_count_out, 0);
        chk({tag, "_snap"}, {ball_x_out, ball_y_out, |pins_x_out, |pins_y_out}, 0);
    endtask

    // Drives a one-cycle request and queues the full expected beat sequence for it.
    task automatic request();
        beat_t b;
        @(negedge clk_in);
        for (int v = SY; v < EY; v++) begin
            for (int h = SX; h < EX; h++) begin
                b.h = 11'(h);
                b.v = 10'(v);
                b.s = (v < RD) ? 2'b11 : 2'b10;
                exp_q.push_back(b);
            end
        end
        exp_bx = ball_x_in;
        exp_by = ball_y_in;
        exp_px = pins_x_in;
        exp_py = pins_y_in;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        chk("snap_ball_x_load", ball_x_out, exp_bx);
        chk("snap_pins_x_load", pins_x_out, exp_px);
    endtask

    task automatic run_frame(input bit rnd, input bit do_ovr, input bit chg, input bit chk_lat,
                             input int rst_at, output bit reset_hit);
        int cyc = 1;
        int beats = 0;
        bit seen = 0;
        bit stall = 0;
        logic [10:0] ph = '0;
        logic [9:0]  pv = '0;
        beat_t e;
        reset_hit = 0;
        chk("busy_after_req", busy_out, 1);
        while (beats < BEATS && cyc < 5000) begin
            coord_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            frame_start_in = do_ovr && (cyc == 30 || cyc == 40 || cyc == 50);
            if (chg && cyc == 40) begin
                ball_x_in = 11'd200;
                pins_x_in = ~pins_x_in;
            end
            if (rst_at >= 0 && beats == rst_at) begin
                #2 rst_in = 1'b1;
                #1 chk_all_zero("rst_mid_scan");
                frame_start_in = 1'b0;
                reset_hit = 1;
                return;
            end
            chk("done_mid_frame", frame_done_out, 0);
            if (coord_valid_out) begin
                if (!seen) begin
                    seen = 1;
                    if (chk_lat) chk("first_beat_latency", cyc, ST + 2);
                end
                if (stall) begin
                    chk("hold_h", hcount_out, ph);
                    chk("hold_v", vcount_out, pv);
                end
                if (coord_ready_in && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_h", hcount_out, e.h);
                    chk("beat_v", vcount_out, e.v);
                    chk("beat_sel", select_objs_out, e.s);
                    beats++;
                end
                stall = !coord_ready_in;
                ph = hcount_out;
                pv = vcount_out;
            end else if (seen) begin
                chk("valid_dropped_mid_frame", coord_valid_out, 1);
            end
            @(negedge clk_in);
            cyc++;
        end
        frame_start_in = 1'b0;
        coord_ready_in = 1'b1;
        chk("frame_within_budget", cyc < 5000, 1);
        chk("done_pulse", frame_done_out, 1);
        chk("busy_in_done", busy_out, 1);
        chk("valid_after_last", coord_valid_out, 0);
        @(negedge clk_in);
        chk("done_single", frame_done_out, 0);
        chk("busy_fall", busy_out, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("snap_ball_x_hold", ball_x_out, exp_bx);
        chk("snap_ball_y_hold", ball_y_out, exp_by);
        chk("snap_pins_x_hold", pins_x_out, exp_px);
        chk("snap_pins_y_hold", pins_y_out, exp_py);
        $display("frame done: beats=%0d cycles=%0d overruns=%0d", beats, cyc, overrun_count_out);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            pins_x_in[i] = 11'($urandom);
            pins_y_in[i] = 10'($urandom);
        end
        #2 chk_all_zero("reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_all_zero("after_release");

        // Ready tied high, three overrun pulses mid-scan, live scene changes during the pass.
        request();
        run_frame(0, 1, 1, 1, -1, was_reset);
        chk("overrun_three", overrun_count_out, 3);

        // Backpressure: new scene (ball_x=200) must load on this request.
        request();
        chk("snap_ball_x_200", ball_x_out, 200);
        run_frame(1, 0, 0, 1, -1, was_reset);

        // Overrun saturation while the first beat is stalled.
        coord_ready_in = 1'b0;
        request();
        frame_start_in = 1'b1;
        repeat (300) @(negedge clk_in);
        frame_start_in = 1'b0;
        chk("overrun_saturate", overrun_count_out, 255);
        run_frame(0, 0, 0, 0, -1, was_reset);

        // Reset in the middle of a scan.
        request();
        run_frame(0, 0, 0, 1, 50, was_reset);
        chk("reset_reached", was_reset, 1);
        repeat (3) begin
            @(negedge clk_in);
            chk("no_done_in_reset", frame_done_out, 0);
            chk("no_valid_in_reset", coord_valid_out, 0);
        end
        rst_in = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_in);
        chk("idle_after_reset", busy_out, 0);
        chk("no_done_after_reset", frame_done_out, 0);
        request();
        run_frame(0, 0, 0, 1, -1, was_reset);
        chk("overrun_cleared", overrun_count_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
